// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake and bus bundle between the fetch queue and its
// surroundings (execute redirect, instruction ROM, decode stage).
//   master : the fetch queue side (drives ROM address and decode outputs)
//   slave  : the environment side (drives redirect, ROM data and decode ready)
interface fetch_queue_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          flush_i;
    logic [DW-1:0] flush_pc_i;
    logic [DW-1:0] imem_addr_o;
    logic [DW-1:0] imem_data_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] instr_o;
    logic [DW-1:0] pc_o;
    logic [DW-1:0] inc_pc_o;
    logic [CW-1:0] count_o;

    modport master (
        input  flush_i, flush_pc_i, imem_data_i, ready_i,
        output imem_addr_o, valid_o, instr_o, pc_o, inc_pc_o, count_o
    );

    modport slave (
        output flush_i, flush_pc_i, imem_data_i, ready_i,
        input  imem_addr_o, valid_o, instr_o, pc_o, inc_pc_o, count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage in front of decode. Holds the fetch PC, drives the
// combinational ROM address and buffers {instr, pc} pairs in a DEPTH-entry
// FIFO so decode may stall. A flush from execute empties the queue and
// redirects the fetch PC (word aligned).
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   fq     fetch_queue_if.master: flush/flush_pc, imem addr/data,
//          valid/ready head handshake with instr/pc/inc_pc, count
module fetch_queue #(
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  fq
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0]             fetch_pc;
    logic [AW-1:0]             rd_ptr, wr_ptr;
    logic [CW-1:0]             count;
    logic [DEPTH-1:0][DW-1:0]  mem_instr, mem_pc;
    logic                      valid, pop, push;

    assign valid = (count != '0);
    assign pop   = valid & fq.ready_i;
    // A pop frees a slot in the same cycle, so a full queue keeps streaming.
    assign push  = !fq.flush_i & ((count != FULL) | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (fq.flush_i) begin
            // Any pop this cycle already completed its handshake; the rest is dropped.
            fetch_pc <= fq.flush_pc_i & ~DW'(3);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + DW'(4);
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= fq.imem_data_i;
            mem_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign fq.imem_addr_o = fetch_pc;
    assign fq.valid_o     = valid;
    assign fq.count_o     = count;
    // Head fields read as zero while empty rather than exposing stale entries.
    assign fq.instr_o     = valid ? mem_instr[rd_ptr] : '0;
    assign fq.pc_o        = valid ? mem_pc[rd_ptr] : '0;
    assign fq.inc_pc_o    = valid ? mem_pc[rd_ptr] + DW'(4) : '0;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.DW(DW), .DEPTH(DEPTH)) fq_if ();

    fetch_queue #(.DW(DW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq_if.master)
    );

    function automatic logic [DW-1:0] rom(input logic [DW-1:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    // ROM answers combinationally from the DUT's address.
    assign fq_if.imem_data_i = rom(fq_if.imem_addr_o);

    int            n_chk  = 0;
    int            n_pass = 0;
    ent_t          sb[$];
    logic [DW-1:0] m_pc   = '0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic check_state();
        chk("count",  DW'(fq_if.count_o), DW'(sb.size()));
        chk("valid",  DW'(fq_if.valid_o), DW'(sb.size() != 0));
        chk("addr",   fq_if.imem_addr_o, m_pc);
        if (sb.size() != 0) begin
            chk("instr",  fq_if.instr_o,  sb[0].instr);
            chk("pc",     fq_if.pc_o,     sb[0].pc);
            chk("inc_pc", fq_if.inc_pc_o, sb[0].pc + 32'd4);
        end else begin
            chk("e_instr",  fq_if.instr_o,  '0);
            chk("e_pc",     fq_if.pc_o,     '0);
            chk("e_inc_pc", fq_if.inc_pc_o, '0);
        end
    endtask

    // Called just after a negedge: check, drive, advance model, wait next negedge.
    task automatic cyc(input logic rdy, input logic fl, input logic [DW-1:0] fpc);
        logic pop, push;
        check_state();
        fq_if.ready_i    = rdy;
        fq_if.flush_i    = fl;
        fq_if.flush_pc_i = fpc;
        pop  = rdy && (sb.size() != 0);
        push = !fl && ((sb.size() < DEPTH) || pop);
        if (pop) void'(sb.pop_front());
        if (fl) begin
            sb.delete();
            m_pc = {fpc[DW-1:2], 2'b00};
        end else if (push) begin
            sb.push_back('{instr: rom(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        fq_if.ready_i    = 1'b1;
        fq_if.flush_i    = 1'b0;
        fq_if.flush_pc_i = '0;
        repeat (2) @(negedge clk);
        check_state();                 // reset state
        rst = 1'b1;

        // 1: streaming from reset
        repeat (8) cyc(1'b1, 1'b0, '0);

        // 2: stall fills queue, then drain in order
        cyc(1'b1, 1'b1, 32'h0);
        repeat (10) cyc(1'b0, 1'b0, '0);
        chk("t2_cnt",  DW'(fq_if.count_o), 32'd4);
        chk("t2_addr", fq_if.imem_addr_o, 32'h10);
        // 3: full with ready every cycle, count stays at DEPTH
        repeat (8) cyc(1'b1, 1'b0, '0);
        chk("t3_cnt", DW'(fq_if.count_o), 32'd4);

        // 4: flush while count=3
        cyc(1'b1, 1'b1, 32'h80);
        repeat (3) cyc(1'b0, 1'b0, '0);
        chk("t4_cnt3", DW'(fq_if.count_o), 32'd3);
        cyc(1'b0, 1'b1, 32'h40);
        chk("t4_valid", DW'(fq_if.valid_o), 32'd0);
        chk("t4_addr",  fq_if.imem_addr_o, 32'h40);
        cyc(1'b0, 1'b0, '0);
        chk("t4_pc", fq_if.pc_o, 32'h40);
        repeat (2) cyc(1'b0, 1'b0, '0);

        // 5: unaligned target, flush coinciding with pop
        cyc(1'b1, 1'b1, 32'h43);
        chk("t5_addr", fq_if.imem_addr_o, 32'h40);
        repeat (4) cyc(1'b1, 1'b0, '0);

        // back-to-back flushes, last wins
        cyc(1'b0, 1'b1, 32'h100);
        cyc(1'b0, 1'b1, 32'h200);
        repeat (3) cyc(1'b1, 1'b0, '0);

        // fetch PC and inc_pc wrap at 2^DW
        cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (3) cyc(1'b0, 1'b0, '0);
        repeat (6) cyc(1'b1, 1'b0, '0);

        // 6: async reset with count=2
        cyc(1'b0, 1'b1, 32'h300);
        repeat (2) cyc(1'b0, 1'b0, '0);
        chk("t6_cnt2", DW'(fq_if.count_o), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", DW'(fq_if.valid_o), 32'd0);
        chk("t6_cnt",   DW'(fq_if.count_o), 32'd0);
        chk("t6_addr",  fq_if.imem_addr_o, 32'h0);
        sb.delete();
        m_pc = '0;
        @(negedge clk);
        check_state();
        rst = 1'b1;
        repeat (6) cyc(1'b1, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
